crc32_par: RTL and testbench

CRC32_PAR -- requirements
Module: crc32_par

---
 rtl/crc32_pkg.sv | 29 ++
 rtl/crc32_byte.sv | 17 +
 rtl/crc32_par.sv | 152 +++++++++++++++
 tb/tb_crc32_par.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc32_pkg.sv
// crc32_pkg: shared CRC/Adler constants, FSM state type and Adler byte step.
package crc32_pkg;

   localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;
   localparam logic [16:0] ADLER_MOD  = 17'd65521;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIN
   } state_t;

   // {B,A} operands stay below the modulus, so one conditional subtract each
   function automatic logic [31:0] adler_byte(
      input logic [31:0] i_ab,
      input logic [7:0]  i_dat
   );
      logic [16:0] a;
      logic [16:0] b;
      a = {1'b0, i_ab[15:0]} + {9'd0, i_dat};
      if (a >= ADLER_MOD) a = a - ADLER_MOD;
      b = {1'b0, i_ab[31:16]} + a;
      if (b >= ADLER_MOD) b = b - ADLER_MOD;
      return {b[15:0], a[15:0]};
   endfunction

endpackage

// File: rtl/crc32_byte.sv
// crc32_byte: one byte of reflected CRC-32, purely combinational.
module crc32_byte
   import crc32_pkg::*;
(
   input  logic [31:0] i_crc,
   input  logic [7:0]  i_dat,
   output logic [31:0] o_crc
);

   always_comb begin
      o_crc = i_crc ^ {24'd0, i_dat};
      for (int i = 0; i < 8; i++) begin
         o_crc = o_crc[0] ? ((o_crc >> 1) ^ CRC_POLY) : (o_crc >> 1);
      end
   end

endmodule

// File: rtl/crc32_par.sv
// crc32_par: beat-parallel PNG/zlib CRC-32 with a byte-tap chain.
// Define CRC32_PAR_ADLER_EN to add the adl_o Adler-32 output.
module crc32_par
   import crc32_pkg::*;
#(
   parameter int DATA_WD = 32,
   parameter int BYT_NUM = DATA_WD / 8,
   parameter int CNT_WD  = $clog2(BYT_NUM + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               val_i,
   output logic               rdy_o,
   input  logic [DATA_WD-1:0] dat_i,
   input  logic               lst_i,
   input  logic [CNT_WD-1:0]  cnt_i,
   output logic               val_o,
   output logic               done_o,
   output logic [31:0]        dat_o
`ifdef CRC32_PAR_ADLER_EN
   ,
   output logic [31:0]        adl_o
`endif
);

   state_t      r_state;
   state_t      w_nxt;
   logic        w_acc;
   logic [31:0] w_n;
   logic [31:0] r_acc;
   logic [31:0] r_dat;
   logic        r_val;
   logic        r_done;
   logic [31:0] w_tap [BYT_NUM];
   logic [31:0] w_crc;

   // a start in the same cycle wins over any beat
   assign w_acc = val_i && rdy_o && !start_i;
   assign w_n   = 32'(cnt_i);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (start_i) w_nxt = ST_RUN;
         ST_RUN: begin
            if (start_i)             w_nxt = ST_RUN;
            else if (w_acc && lst_i) w_nxt = ST_FIN;
         end
         ST_FIN:  w_nxt = start_i ? ST_RUN : ST_IDLE;
         default: w_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      rdy_o = (r_state == ST_RUN);
   end

   for (genvar k = 0; k < BYT_NUM; k++) begin : g_byte
      logic [31:0] w_ci;
      logic [31:0] w_co;
      if (k == 0) begin : g_first
         assign w_ci = r_acc;
      end else begin : g_next
         assign w_ci = g_byte[k-1].w_co;
      end
      crc32_byte u_byte (
         .i_crc (w_ci),
         .i_dat (dat_i[DATA_WD-1-8*k -: 8]),
         .o_crc (w_co)
      );
      assign w_tap[k] = w_co;
   end

   // cnt_i of 0 (or out of range) keeps the full-beat tap
   always_comb begin
      w_crc = w_tap[BYT_NUM-1];
      if (lst_i) begin
         for (int k = 0; k < BYT_NUM; k++) begin
            if (w_n == 32'(k + 1)) w_crc = w_tap[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc  <= CRC_INIT;
         r_dat  <= 32'd0;
         r_val  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_val  <= w_acc;
         r_done <= w_acc && lst_i;
         if (start_i) begin
            r_acc <= CRC_INIT;
         end else if (w_acc) begin
            r_acc <= w_crc;
            r_dat <= w_crc ^ CRC_XOROUT;
         end
      end
   end

   assign val_o  = r_val;
   assign done_o = r_done;
   assign dat_o  = r_dat;

`ifdef CRC32_PAR_ADLER_EN
   logic [31:0] r_adl_acc;
   logic [31:0] r_adl;
   logic [31:0] w_atap [BYT_NUM];
   logic [31:0] w_adl;

   for (genvar k = 0; k < BYT_NUM; k++) begin : g_adl
      logic [31:0] w_ai;
      if (k == 0) begin : g_first
         assign w_ai = r_adl_acc;
      end else begin : g_next
         assign w_ai = w_atap[k-1];
      end
      assign w_atap[k] = adler_byte(w_ai, dat_i[DATA_WD-1-8*k -: 8]);
   end

   always_comb begin
      w_adl = w_atap[BYT_NUM-1];
      if (lst_i) begin
         for (int k = 0; k < BYT_NUM; k++) begin
            if (w_n == 32'(k + 1)) w_adl = w_atap[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_adl_acc <= 32'd1;
         r_adl     <= 32'd1;
      end else if (start_i) begin
         r_adl_acc <= 32'd1;
      end else if (w_acc) begin
         r_adl_acc <= w_adl;
         r_adl     <= w_adl;
      end
   end

   assign adl_o = r_adl;
`endif

endmodule

// File: tb/tb_crc32_par.sv
// tb_crc32_par: scoreboard bench over 8/32/64-bit beat widths.
// Adler-32 checks are active when CRC32_PAR_ADLER_EN is defined.
module tb_crc32_par;
   import crc32_pkg::*;

   typedef struct {
      logic [31:0] crc;
      logic        done;
      logic [31:0] adl;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   logic        s32, v32, l32, r32, vo32, do32;
   logic [31:0] d32, o32, a32;
   logic [2:0]  c32;
   logic        s8, v8, l8, r8, vo8, do8;
   logic [7:0]  d8;
   logic [31:0] o8, a8;
   logic [0:0]  c8;
   logic        s64, v64, l64, r64, vo64, do64;
   logic [63:0] d64;
   logic [31:0] o64, a64;
   logic [3:0]  c64;

   crc32_par #(.DATA_WD(32)) u32 (
      .clk(clk), .rst(rst), .start_i(s32), .val_i(v32), .rdy_o(r32),
      .dat_i(d32), .lst_i(l32), .cnt_i(c32), .val_o(vo32),
      .done_o(do32), .dat_o(o32)
`ifdef CRC32_PAR_ADLER_EN
      , .adl_o(a32)
`endif
   );

   crc32_par #(.DATA_WD(8)) u8 (
      .clk(clk), .rst(rst), .start_i(s8), .val_i(v8), .rdy_o(r8),
      .dat_i(d8), .lst_i(l8), .cnt_i(c8), .val_o(vo8),
      .done_o(do8), .dat_o(o8)
`ifdef CRC32_PAR_ADLER_EN
      , .adl_o(a8)
`endif
   );

   crc32_par #(.DATA_WD(64)) u64 (
      .clk(clk), .rst(rst), .start_i(s64), .val_i(v64), .rdy_o(r64),
      .dat_i(d64), .lst_i(l64), .cnt_i(c64), .val_o(vo64),
      .done_o(do64), .dat_o(o64)
`ifdef CRC32_PAR_ADLER_EN
      , .adl_o(a64)
`endif
   );

`ifndef CRC32_PAR_ADLER_EN
   assign a32 = 32'd0;
   assign a8  = 32'd0;
   assign a64 = 32'd0;
`endif

   // bit-at-a-time reference models
   function automatic logic [31:0] m_crc(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   function automatic logic [31:0] m_adl(input logic [31:0] ab, input logic [7:0] d);
      int a;
      int b;
      a = int'(ab[15:0]);
      b = int'(ab[31:16]);
      a = (a + int'(d)) % 65521;
      b = (b + a) % 65521;
      return 32'((b << 16) | a);
   endfunction

   exp_t q32[$];
   exp_t q8[$];
   exp_t q64[$];
   logic [31:0] mc32, ma32, mc8, ma8, mc64, ma64;
   int dn32 = 0, dn8 = 0, dn64 = 0;
   int dc32 = 0, dc8 = 0, dc64 = 0;
   int cs32 = 0, cs8 = 0, cs64 = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h required %h", nm, act, req);
      end
   endtask

   task automatic cmp(input string nm, input exp_t e, input logic [31:0] d,
                      input logic dn, input logic [31:0] a);
      logic bad;
      checks++;
      bad = (d !== e.crc) || (dn !== e.done);
`ifdef CRC32_PAR_ADLER_EN
      bad = bad || (a !== e.adl);
`endif
      if (bad) begin
         errors++;
         $display("FAIL %s dat_o=%h done_o=%b adl=%h required %h %b %h",
                  nm, d, dn, a, e.crc, e.done, e.adl);
      end
   endtask

   task automatic stray(input string nm, input logic [31:0] d);
      checks++;
      errors++;
      $display("FAIL %s strobe with dat_o=%h required no strobe", nm, d);
   endtask

   always @(negedge clk) begin
      if (vo32) begin
         if (q32.size() == 0) stray("u32 val_o", o32);
         else cmp("u32 beat", q32.pop_front(), o32, do32, a32);
      end else if (do32) stray("u32 done_o", o32);
      if (do32) begin dn32++; dc32 = cyc; end
   end

   always @(negedge clk) begin
      if (vo8) begin
         if (q8.size() == 0) stray("u8 val_o", o8);
         else cmp("u8 beat", q8.pop_front(), o8, do8, a8);
      end else if (do8) stray("u8 done_o", o8);
      if (do8) begin dn8++; dc8 = cyc; end
   end

   always @(negedge clk) begin
      if (vo64) begin
         if (q64.size() == 0) stray("u64 val_o", o64);
         else cmp("u64 beat", q64.pop_front(), o64, do64, a64);
      end else if (do64) stray("u64 done_o", o64);
      if (do64) begin dn64++; dc64 = cyc; end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // v drives a beat alongside start; it must never be accepted
   task automatic start32(input logic v);
      cs32 = cyc;
      s32 = 1'b1; v32 = v; d32 = 32'hDEADBEEF; l32 = 1'b1; c32 = 3'd4;
      tick();
      s32 = 1'b0; v32 = 1'b0; l32 = 1'b0;
      mc32 = CRC_INIT; ma32 = 32'd1;
   endtask

   task automatic beat32(input logic [31:0] d, input logic l,
                         input logic [2:0] c, input int gap);
      int n;
      repeat (gap) begin
         v32 = 1'b0; l32 = 1'($urandom_range(1));
         tick();
      end
      chk("u32 rdy_o", {31'd0, r32}, 32'd1);
      v32 = 1'b1; d32 = d; l32 = l; c32 = c;
      n = (l && c != 3'd0) ? int'(c) : 4;
      for (int i = 0; i < n; i++) begin
         mc32 = m_crc(mc32, d[31-8*i -: 8]);
         ma32 = m_adl(ma32, d[31-8*i -: 8]);
      end
      q32.push_back('{mc32 ^ 32'hFFFFFFFF, l, ma32});
      tick();
      v32 = 1'b0; l32 = 1'b0;
   endtask

   task automatic beat8(input logic [7:0] d, input logic l);
      v8 = 1'b1; d8 = d; l8 = l; c8 = 1'b0;
      mc8 = m_crc(mc8, d);
      ma8 = m_adl(ma8, d);
      q8.push_back('{mc8 ^ 32'hFFFFFFFF, l, ma8});
      tick();
      v8 = 1'b0; l8 = 1'b0;
   endtask

   task automatic beat64(input logic [63:0] d, input logic l, input logic [3:0] c);
      int n;
      v64 = 1'b1; d64 = d; l64 = l; c64 = c;
      n = (l && c != 4'd0) ? int'(c) : 8;
      for (int i = 0; i < n; i++) begin
         mc64 = m_crc(mc64, d[63-8*i -: 8]);
         ma64 = m_adl(ma64, d[63-8*i -: 8]);
      end
      q64.push_back('{mc64 ^ 32'hFFFFFFFF, l, ma64});
      tick();
      v64 = 1'b0; l64 = 1'b0;
   endtask

   task automatic nine32(input int gmax);
      beat32(32'h31323334, 1'b0, 3'd0, $urandom_range(gmax));
      beat32(32'h35363738, 1'b0, 3'd0, $urandom_range(gmax));
      beat32(32'h39000000, 1'b1, 3'd1, $urandom_range(gmax));
      tick(); tick();
   endtask

   int dsave;

   initial begin
      rst = 1'b1;
      s32 = 0; v32 = 0; l32 = 0; d32 = 0; c32 = 0;
      s8 = 0; v8 = 0; l8 = 0; d8 = 0; c8 = 0;
      s64 = 0; v64 = 0; l64 = 0; d64 = 0; c64 = 0;
      mc32 = 0; ma32 = 0; mc8 = 0; ma8 = 0; mc64 = 0; ma64 = 0;
      repeat (3) tick();

      chk("reset rdy_o", {31'd0, r32}, 32'd0);
      chk("reset val_o", {31'd0, vo32}, 32'd0);
      chk("reset done_o", {31'd0, do32}, 32'd0);
      chk("reset dat_o", o32, 32'd0);
      chk("reset u64 dat_o", o64, 32'd0);
`ifdef CRC32_PAR_ADLER_EN
      chk("reset adl_o", a32, 32'd1);
`endif
      rst = 1'b0;
      tick();

      // IEND chunk CRC
      start32(1'b0);
      beat32(32'h49454E44, 1'b1, 3'd4, 0);
      tick(); tick();
      chk("iend dat_o", o32, 32'hAE426082);
      chk("iend done count", 32'(dn32), 32'd1);
      chk("iend latency", 32'(dc32 - cs32), 32'd2);

      // start with val in IDLE, then the check string
      start32(1'b1);
      nine32(0);
      chk("nine dat_o", o32, 32'hCBF43926);
      chk("nine latency", 32'(dc32 - cs32), 32'd4);
`ifdef CRC32_PAR_ADLER_EN
      chk("nine adl_o", a32, 32'h091E01DE);
`endif
      repeat (3) tick();
      chk("hold dat_o", o32, 32'hCBF43926);
      chk("idle rdy_o", {31'd0, r32}, 32'd0);

      // gaps in val_i, lst_i toggling while idle
      start32(1'b0);
      nine32(3);
      chk("gap dat_o", o32, 32'hCBF43926);

      // partial last beats
      start32(1'b0);
      beat32(32'h49455A5A, 1'b1, 3'd2, 0);
      tick(); tick();
      start32(1'b0);
      beat32(32'h313233A5, 1'b1, 3'd3, 1);
      tick(); tick();

      // abort after two beats, restart with a colliding beat
      dsave = dn32;
      start32(1'b0);
      beat32(32'h31323334, 1'b0, 3'd0, 0);
      beat32(32'h35363738, 1'b0, 3'd0, 0);
      start32(1'b1);
      beat32(32'h49454E44, 1'b1, 3'd4, 0);
      tick(); tick();
      chk("abort dat_o", o32, 32'hAE426082);
      chk("abort done count", 32'(dn32 - dsave), 32'd1);

      // reset mid-stream
      dsave = dn32;
      start32(1'b0);
      beat32(32'h31323334, 1'b0, 3'd0, 0);
      v32 = 1'b1; d32 = 32'h35363738; l32 = 1'b1; c32 = 3'd0;
      rst = 1'b1;
      tick();
      chk("mid rst rdy_o", {31'd0, r32}, 32'd0);
      chk("mid rst val_o", {31'd0, vo32}, 32'd0);
      chk("mid rst done_o", {31'd0, do32}, 32'd0);
      chk("mid rst dat_o", o32, 32'd0);
      v32 = 1'b0; l32 = 1'b0; rst = 1'b0;
      repeat (2) tick();
      chk("mid rst no done", 32'(dn32 - dsave), 32'd0);
      start32(1'b0);
      nine32(1);
      chk("post rst dat_o", o32, 32'hCBF43926);

      // 8-bit beats
      cs8 = cyc;
      s8 = 1'b1; tick(); s8 = 1'b0;
      mc8 = CRC_INIT; ma8 = 32'd1;
      for (int i = 0; i < 9; i++) beat8(8'(8'h31 + i), i == 8);
      tick(); tick();
      chk("u8 dat_o", o8, 32'hCBF43926);
      chk("u8 latency", 32'(dc8 - cs8), 32'd10);
`ifdef CRC32_PAR_ADLER_EN
      chk("u8 adl_o", a8, 32'h091E01DE);
`endif

      // 64-bit beats
      cs64 = cyc;
      s64 = 1'b1; tick(); s64 = 1'b0;
      mc64 = CRC_INIT; ma64 = 32'd1;
      beat64(64'h3132333435363738, 1'b0, 4'd0);
      beat64(64'h39FFFFFFFFFFFFFF, 1'b1, 4'd1);
      tick(); tick();
      chk("u64 dat_o", o64, 32'hCBF43926);
      chk("u64 latency", 32'(dc64 - cs64), 32'd3);
`ifdef CRC32_PAR_ADLER_EN
      chk("u64 adl_o", a64, 32'h091E01DE);
`endif

      repeat (3) tick();
      chk("u32 queue drained", 32'(q32.size()), 32'd0);
      chk("u8 queue drained", 32'(q8.size()), 32'd0);
      chk("u64 queue drained", 32'(q64.size()), 32'd0);
      chk("u8 done count", 32'(dn8), 32'd1);
      chk("u64 done count", 32'(dn64), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
